// File: rtl/mips_pkg.sv
// mips_pkg: shared decode types and encodings for the MIPS pipeline.
// Holds the control bundle, opcode/funct values, ALU control codes and the NOP word.
package mips_pkg;

    typedef struct packed {
        logic       regwrite;
        logic       regdst;
        logic       alusrc;
        logic       memtoreg;
        logic       memwrite;
        logic       branch;
        logic       branchne;
        logic [2:0] alucontrol;
    } ctrl_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;

    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [31:0] NOP = 32'h0;

endpackage

// File: rtl/regfile.sv
// regfile: 32x32 register file, two read ports, one write port, async active-low clear.
// r0 is hard-wired to zero. Defining DECODE_BYPASS_EN makes a same-cycle
// writeback visible on the read ports (write-through); otherwise reads see the stored value.
module regfile
(
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);

    logic [31:0] regs [32];
    logic        wr_active;

    assign wr_active = we && (wa != 5'd0);

    // Storage: cleared asynchronously, written on the rising edge except for r0
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_active) begin
            regs[wa] <= wd;
        end
    end

`ifdef DECODE_BYPASS_EN
    // Read ports with write-through so the decode stage sees this cycle's writeback
    always_comb begin
        rd1 = (ra1 == 5'd0) ? 32'h0 : regs[ra1];
        rd2 = (ra2 == 5'd0) ? 32'h0 : regs[ra2];
        if (wr_active && (wa == ra1)) rd1 = wd;
        if (wr_active && (wa == ra2)) rd2 = wd;
    end
`else
    // Read ports return the stored value; a same-cycle writeback shows up next cycle
    always_comb begin
        rd1 = (ra1 == 5'd0) ? 32'h0 : regs[ra1];
        rd2 = (ra2 == 5'd0) ? 32'h0 : regs[ra2];
    end
`endif

endmodule

// File: rtl/stage_decode.sv
// stage_decode: ID stage of the MIPS pipeline. IF/ID register, register file read,
// control decode, sign extension and early beq/bne resolution back to fetch.
// DECODE_BYPASS_EN (in regfile) enables WB-to-ID write-through on the read ports.
module stage_decode
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_IF,
    input  logic [31:0] pcplus4_IF,
    input  logic        stall,
    input  logic        regwrite_WB,
    input  logic [4:0]  writereg_WB,
    input  logic [31:0] result_WB,
    output logic [31:0] pcbranch,
    output logic        pcsrc,
    output ctrl_t       ctrl,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    output logic [31:0] signimm,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic        illegal
);

    logic [31:0] instr_id;
    logic [31:0] pcplus4_id;
    logic        valid_id;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        eq;

    // IF/ID register: reset clears, stall holds, a taken branch flushes the wrong-path fetch
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_id   <= NOP;
            pcplus4_id <= '0;
            valid_id   <= 1'b0;
        end else if (stall) begin
            instr_id   <= instr_id;
            pcplus4_id <= pcplus4_id;
            valid_id   <= valid_id;
        end else if (pcsrc) begin
            instr_id   <= NOP;
            pcplus4_id <= '0;
            valid_id   <= 1'b0;
        end else begin
            instr_id   <= instr_IF;
            pcplus4_id <= pcplus4_IF;
            valid_id   <= 1'b1;
        end
    end

    assign op      = instr_id[31:26];
    assign funct   = instr_id[5:0];
    assign rs      = instr_id[25:21];
    assign rt      = instr_id[20:16];
    assign rd      = instr_id[15:11];
    assign signimm = {{16{instr_id[15]}}, instr_id[15:0]};

    regfile u_regfile (
        .clk   (clk),
        .reset (reset),
        .ra1   (rs),
        .ra2   (rt),
        .we    (regwrite_WB),
        .wa    (writereg_WB),
        .wd    (result_WB),
        .rd1   (rd1),
        .rd2   (rd2)
    );

    // Control decode; the all-zero NOP word is a legal no-op rather than an unsupported sll
    always_comb begin
        ctrl    = '0;
        illegal = 1'b0;
        if (valid_id && (instr_id != NOP)) begin
            case (op)
                OP_RTYPE: begin
                    ctrl.regwrite = 1'b1;
                    ctrl.regdst   = 1'b1;
                    case (funct)
                        FUNCT_ADD: ctrl.alucontrol = ALU_ADD;
                        FUNCT_SUB: ctrl.alucontrol = ALU_SUB;
                        FUNCT_AND: ctrl.alucontrol = ALU_AND;
                        FUNCT_OR:  ctrl.alucontrol = ALU_OR;
                        FUNCT_SLT: ctrl.alucontrol = ALU_SLT;
                        default: begin
                            ctrl    = '0;
                            illegal = 1'b1;
                        end
                    endcase
                end
                OP_LW: begin
                    ctrl.regwrite   = 1'b1;
                    ctrl.alusrc     = 1'b1;
                    ctrl.memtoreg   = 1'b1;
                    ctrl.alucontrol = ALU_ADD;
                end
                OP_SW: begin
                    ctrl.memwrite   = 1'b1;
                    ctrl.alusrc     = 1'b1;
                    ctrl.alucontrol = ALU_ADD;
                end
                OP_ADDI: begin
                    ctrl.regwrite   = 1'b1;
                    ctrl.alusrc     = 1'b1;
                    ctrl.alucontrol = ALU_ADD;
                end
                OP_BEQ: begin
                    ctrl.branch     = 1'b1;
                    ctrl.alucontrol = ALU_SUB;
                end
                OP_BNE: begin
                    ctrl.branchne   = 1'b1;
                    ctrl.alucontrol = ALU_SUB;
                end
                default: begin
                    ctrl    = '0;
                    illegal = 1'b1;
                end
            endcase
        end
    end

    // Early branch resolution; a stall suppresses the redirect until the branch can advance
    always_comb begin
        eq       = (rd1 == rd2);
        pcsrc    = ~stall & ((ctrl.branch & eq) | (ctrl.branchne & ~eq));
        pcbranch = pcplus4_id + (signimm << 2);
    end

endmodule

// File: doc/stage_decode.md
# stage_decode

Second stage of the MIPS pipeline, directly downstream of the fetch stage. Captures the fetched instruction and its PC+4 in the IF/ID register, reads the 32×32 register file, generates control signals and the sign-extended immediate, and resolves beq/bne early. The branch target and branch select are returned to fetch.

## Interface
- No parameters; widths are fixed by the ISA.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- instr_IF  in  32  instruction from fetch
- pcplus4_IF  in  32  PC+4 from fetch
- stall  in  1  hazard unit: hold IF/ID contents
- regwrite_WB  in  1  writeback enable
- writereg_WB  in  5  writeback destination
- result_WB  in  32  writeback data
- pcbranch  out  32  branch target to fetch
- pcsrc  out  1  branch taken, select pcbranch in fetch
- ctrl  out  ctrl_t  decoded control bundle to the ID/EX register
- rd1, rd2  out  32  register operands for rs and rt
- signimm  out  32  sign-extended imm[15:0]
- rs, rt, rd  out  5  instruction fields, for forwarding and hazard logic
- illegal  out  1  opcode or funct is not supported

## Operation
- **IF/ID register** holds instr, pcplus4 and valid. Priority order:
  - reset: all fields 0.
  - stall=1: hold the current contents.
  - pcsrc=1: flush. instr=0, valid=0.
  - otherwise: load instr_IF and pcplus4_IF, set valid=1.
- **Register file:** 32×32.
  - Write happens on the rising edge when regwrite_WB=1 and writereg_WB≠0.
  - Register r0 always reads 0.
  - Reset clears all entries to 0.
- **Decode** is purely combinational from IF/ID. When valid=0, ctrl is all-zero and illegal=0.
  - R-type (op 0x00) sets regwrite and regdst. alucontrol by funct: add 0x20 gives 010; sub 0x22 gives 110; and 0x24 gives 000; or 0x25 gives 001; slt 0x2A gives 111.
  - lw 0x23: regwrite, alusrc, memtoreg, alucontrol 010.
  - sw 0x2B: memwrite, alusrc, alucontrol 010.
  - addi 0x08: regwrite, alusrc, alucontrol 010.
  - beq 0x04 sets branch; bne 0x05 sets branchne. Both use alucontrol 110.
  - Any other opcode, or any other R-type funct: ctrl is all-zero and illegal=1.
- **Branch:**
  - eq = (rd1 == rd2).
  - pcsrc = ~stall & ((branch & eq) | (branchne & ~eq)).
  - pcbranch = pcplus4_ID + (signimm << 2), computed modulo 2^32 (wraps).
- signimm = {{16{instr[15]}}, instr[15:0]}.
- rs = instr[25:21], rt = instr[20:16], rd = instr[15:11].

## Timing
- IF/ID adds 1 cycle. An instruction presented in cycle N is decoded in cycle N+1.
- pcsrc and pcbranch are combinational within the decode cycle. The fetch PC takes pcbranch at the next edge.
- The wrong-path instruction fetched in the same cycle is flushed at that edge. Branch penalty is one bubble.
- Stall and taken branch in the same cycle: stall wins. pcsrc is forced to 0 and the branch re-evaluates the next cycle. The fetch PC enable (~stall) is driven externally.
- Regfile write is visible to a read on the same edge only with bypass enabled (see Configuration). Without bypass it is visible the following cycle.
- Reset values:
  - IF/ID is all 0, so the NOP is decoded and ctrl=0.
  - pcsrc=0, illegal=0.
  - rd1=rd2=0, signimm=0, pcbranch=0.
  - rs=rt=rd=0.
- Asserting reset mid-operation clears IF/ID and the regfile immediately, with no clock edge needed.

## Configuration
- DECODE_BYPASS_EN defined:
  - rd1/rd2 return result_WB when regwrite_WB=1, writereg_WB≠0 and it matches rs/rt.
  - This is a same-cycle write-through, so the branch compare sees WB data.
- Undefined:
  - Reads return the stored value. A WB-to-ID dependency yields the old value.
  - The hazard unit must stall one extra cycle.

## Structure
- mips_pkg holds:
  - ctrl_t packed struct: regwrite, regdst, alusrc, memtoreg, memwrite, branch, branchne, alucontrol[2:0].
  - Opcode and funct localparams.
  - The ALU control encodings.
  - NOP constant 32'h0.
- One sub-module, regfile: 2 read ports, 1 write port, async active-low clear, and the bypass under the macro.
- The IF/ID register, decoder and branch logic stay in stage_decode.

## Test plan
- Reset low with random inputs → all outputs 0. Release reset and present instr_IF=0 → ctrl=0, illegal=0.
- instr_IF=0x012A4020 (add $8,$9,$10) with r9=5, r10=7 → next cycle rs=9, rt=10, rd=8, rd1=5, rd2=7, ctrl.regwrite=1, regdst=1, alucontrol=010.
- beq with rd1=rd2=3, pcplus4_IF=0x100, imm=0xFFFF → pcsrc=1, pcbranch=0xFC. On the following edge IF/ID valid=0 and the next cycle's ctrl=0.
- Same beq with stall=1 for 2 cycles → pcsrc=0 and IF/ID unchanged both cycles. pcsrc=1 once stall drops.
- Write r4=0xDEAD via WB while decoding an instruction that reads r4 → rd1=0xDEAD in that cycle with DECODE_BYPASS_EN, old value without it. A WB write to r0 leaves rd1=0 for rs=0.
- instr_IF=0xFC000000 (op 0x3F) → illegal=1, ctrl=0, pcsrc=0.
